seg7_scan_ctrl: RTL and testbench

//  Time-multiplexed 7-segment display scanner for DIGITS common-select digits.

---
 rtl/seg7_scan_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_ctrl
//  Purpose  : Multiplexed 7-segment scanner with blank gap, leading-zero
//             suppression, PWM brightness and frame-aligned double buffer.
//  Revision : 1.0  initial release
// ============================================================================
module seg7_scan_ctrl #(
   parameter int DIGITS         = 4,
   parameter int DWELL_CLKS     = 10,
   parameter int BLANK_CLKS     = 2,
   parameter int SEL_ACTIVE_LOW = 0,
   parameter int SEG_ACTIVE_LOW = 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [DIGITS*4-1:0]   i_bcd_data,
   input  logic [DIGITS-1:0]     i_dp,
   input  logic                  i_load,
   input  logic                  i_lz_en,
   input  logic [3:0]            i_bright,
   output logic [6:0]            o_seg,
   output logic                  o_dp,
   output logic [DIGITS-1:0]     o_sel,
   output logic                  o_frame_start
);

   localparam int c_CNT_MAX = (DWELL_CLKS > BLANK_CLKS) ? DWELL_CLKS : BLANK_CLKS;
   localparam int c_CW      = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;
   localparam int c_DW      = $clog2(DIGITS);

   localparam logic [c_CW-1:0]   c_DWELL_LAST = c_CW'(DWELL_CLKS - 1);
   localparam logic [c_CW-1:0]   c_BLANK_LAST = c_CW'((BLANK_CLKS > 0) ? BLANK_CLKS - 1 : 0);
   localparam logic [c_DW-1:0]   c_DIGIT_LAST = c_DW'(DIGITS - 1);
   localparam logic              c_SEL_LOW    = (SEL_ACTIVE_LOW != 0);
   localparam logic              c_SEG_LOW    = (SEG_ACTIVE_LOW != 0);
   localparam logic [DIGITS-1:0] c_SEL_OFF    = {DIGITS{c_SEL_LOW}};
   localparam logic [6:0]        c_SEG_OFF    = {7{c_SEG_LOW}};

   typedef enum logic [0:0] {
      S_BLANK = 1'b0,
      S_ON    = 1'b1
   } state_t;

   // With no gap configured every slot starts directly in ON.
   localparam state_t c_ENTRY = (BLANK_CLKS > 0) ? S_BLANK : S_ON;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [c_CW-1:0]   r_cnt;
   logic [c_CW-1:0]   w_cnt_nxt;
   logic [c_DW-1:0]   r_digit;
   logic [c_DW-1:0]   w_digit_nxt;
   logic [3:0]        r_pwm;
   logic [3:0]        w_pwm_nxt;
   logic              w_wrap;

   logic [DIGITS*4-1:0] r_pend_bcd;
   logic [DIGITS-1:0]   r_pend_dp;
   logic                r_pend;
   logic [DIGITS*4-1:0] r_act_bcd;
   logic [DIGITS-1:0]   r_act_dp;

   logic [3:0]          w_nib [DIGITS];
   logic [DIGITS-1:0]   w_dpk;
   logic [DIGITS-1:0]   w_zero;
   logic [DIGITS-1:0]   w_lz_blank;
   logic [DIGITS-1:0]   w_sel_hot;
   logic [3:0]          w_cur_nib;
   logic                w_cur_dp;
   logic                w_cur_blank;
   logic                w_lit;
   logic                w_show;
   logic                w_first;

   function automatic logic [6:0] f_decode(input logic [3:0] bcd);
      logic [6:0] seg;
      case (bcd)
         4'h0:    seg = 7'h3F;
         4'h1:    seg = 7'h06;
         4'h2:    seg = 7'h5B;
         4'h3:    seg = 7'h4F;
         4'h4:    seg = 7'h66;
         4'h5:    seg = 7'h6D;
         4'h6:    seg = 7'h7D;
         4'h7:    seg = 7'h07;
         4'h8:    seg = 7'h7F;
         4'h9:    seg = 7'h6F;
         4'hF:    seg = 7'h40;
         default: seg = 7'h00;
      endcase
      return seg;
   endfunction

   // ------------------------------------------------------------------ FSM
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= c_ENTRY;
         r_cnt   <= '0;
         r_digit <= '0;
         r_pwm   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_digit <= w_digit_nxt;
         r_pwm   <= w_pwm_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + 1'b1;
      w_digit_nxt = r_digit;
      w_pwm_nxt   = r_pwm;
      w_wrap      = 1'b0;
      case (r_state)
         S_BLANK: begin
            if (r_cnt == c_BLANK_LAST) begin
               w_state_nxt = S_ON;
               w_cnt_nxt   = '0;
               w_pwm_nxt   = '0;
            end
         end
         S_ON: begin
            w_pwm_nxt = r_pwm + 1'b1;
            if (r_cnt == c_DWELL_LAST) begin
               w_state_nxt = c_ENTRY;
               w_cnt_nxt   = '0;
               w_pwm_nxt   = '0;
               if (r_digit == c_DIGIT_LAST) begin
                  w_digit_nxt = '0;
                  w_wrap      = 1'b1;
               end else begin
                  w_digit_nxt = r_digit + 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = c_ENTRY;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // ----------------------------------------------------------- buffers
   // The transfer edge is the one entering digit 0, so a whole frame always
   // decodes from one snapshot; a coincident load refills pending for the next.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_pend_bcd <= '0;
         r_pend_dp  <= '0;
         r_pend     <= 1'b0;
         r_act_bcd  <= '0;
         r_act_dp   <= '0;
      end else begin
         if (w_wrap) begin
            if (r_pend) begin
               r_act_bcd <= r_pend_bcd;
               r_act_dp  <= r_pend_dp;
            end
            r_pend <= i_load;
         end else if (i_load) begin
            r_pend <= 1'b1;
         end
         if (i_load) begin
            r_pend_bcd <= i_bcd_data;
            r_pend_dp  <= i_dp;
         end
      end
   end

   // ------------------------------------------------------ per-digit view
   for (genvar K = 0; K < DIGITS; K++) begin : g_digit
      assign w_nib[K]                = r_act_bcd[4*(DIGITS-K)-1 -: 4];
      assign w_dpk[K]                = r_act_dp[DIGITS-1-K];
      assign w_zero[K]               = (r_act_bcd[4*(DIGITS-K)-1 -: 4] == 4'd0) && !r_act_dp[DIGITS-1-K];
      assign w_sel_hot[DIGITS-1-K]   = (r_digit == c_DW'(K));
   end

   // A digit is a leading zero only while every digit to its left is too.
   always_comb begin
      logic v_run;
      v_run      = 1'b1;
      w_lz_blank = '0;
      for (int k = 0; k < DIGITS; k++) begin
         v_run         = v_run & w_zero[k];
         w_lz_blank[k] = i_lz_en & v_run & (k != DIGITS - 1);
      end
   end

   always_comb begin
      w_cur_nib   = 4'd0;
      w_cur_dp    = 1'b0;
      w_cur_blank = 1'b0;
      for (int k = 0; k < DIGITS; k++) begin
         if (r_digit == c_DW'(k)) begin
            w_cur_nib   = w_nib[k];
            w_cur_dp    = w_dpk[k];
            w_cur_blank = w_lz_blank[k];
         end
      end
   end

   assign w_lit   = (i_bright == 4'hF) || (r_pwm < i_bright);
   assign w_show  = (r_state == S_ON) && w_lit && !w_cur_blank;
   assign w_first = (r_state == c_ENTRY) && (r_cnt == '0) && (r_digit == '0);

   // ------------------------------------------------------------ outputs
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_sel         <= c_SEL_OFF;
         o_seg         <= c_SEG_OFF;
         o_dp          <= c_SEG_LOW;
         o_frame_start <= 1'b0;
      end else begin
         o_sel         <= (w_show ? w_sel_hot : '0) ^ c_SEL_OFF;
         o_seg         <= (w_show ? f_decode(w_cur_nib) : 7'h00) ^ c_SEG_OFF;
         o_dp          <= (w_show & w_cur_dp) ^ c_SEG_LOW;
         o_frame_start <= w_first;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_scan_ctrl
//  Purpose  : Directed plus random stimulus for two scanner configurations,
//             compared cycle by cycle against a frame-schedule model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg7_scan_ctrl;

   logic        clk    = 1'b0;
   logic        rst    = 1'b1;
   logic [15:0] bcd    = 16'h0;
   logic [3:0]  dp     = 4'h0;
   logic        load   = 1'b0;
   logic        lz_en  = 1'b0;
   logic [3:0]  bright = 4'hF;

   logic [6:0] a_seg, b_seg;
   logic       a_dp, b_dp, a_fs, b_fs;
   logic [3:0] a_sel, b_sel;

   always #5 clk = ~clk;

   seg7_scan_ctrl #(.DIGITS(4), .DWELL_CLKS(10), .BLANK_CLKS(2),
                    .SEL_ACTIVE_LOW(0), .SEG_ACTIVE_LOW(1)) dut_a (
      .i_clk(clk), .i_rst(rst), .i_bcd_data(bcd), .i_dp(dp), .i_load(load),
      .i_lz_en(lz_en), .i_bright(bright), .o_seg(a_seg), .o_dp(a_dp),
      .o_sel(a_sel), .o_frame_start(a_fs));

   seg7_scan_ctrl #(.DIGITS(4), .DWELL_CLKS(16), .BLANK_CLKS(0),
                    .SEL_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(0)) dut_b (
      .i_clk(clk), .i_rst(rst), .i_bcd_data(bcd), .i_dp(dp), .i_load(load),
      .i_lz_en(lz_en), .i_bright(bright), .o_seg(b_seg), .o_dp(b_dp),
      .o_sel(b_sel), .o_frame_start(b_fs));

   int n_checks = 0;
   int n_errors = 0;

   int P_B   [2] = '{2, 0};
   int P_D   [2] = '{10, 16};
   int P_SELL[2] = '{0, 1};
   int P_SEGL[2] = '{1, 0};

   int          m_s   [2];
   logic [15:0] m_act [2];
   logic [15:0] m_pend[2];
   logic [3:0]  m_adp [2];
   logic [3:0]  m_pdp [2];
   bit          m_flag[2];

   logic [3:0] e_sel[2];
   logic [6:0] e_seg[2];
   logic       e_dp [2];
   logic       e_fs [2];

   function automatic logic [6:0] glyph(input logic [3:0] v);
      case (v)
         4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;
         4'd3: return 7'h4F;  4'd4: return 7'h66;  4'd5: return 7'h6D;
         4'd6: return 7'h7D;  4'd7: return 7'h07;  4'd8: return 7'h7F;
         4'd9: return 7'h6F;  4'hF: return 7'h40;
         default: return 7'h00;
      endcase
   endfunction

   function automatic logic [3:0] nibble(input logic [15:0] v, input int k);
      return v[4*(3-k) +: 4];
   endfunction

   // Schedule index s counts cycles since reset release; the pins after an
   // edge show slot position s, the buffers swap as s rolls into a new frame.
   task automatic model_edge(input int i);
      int slot, period, p, dig, w, pwm;
      bit lit, allz;
      logic [3:0] sel;
      logic [6:0] seg;
      logic       d;
      sel = 4'h0; seg = 7'h00; d = 1'b0;
      slot   = P_B[i] + P_D[i];
      period = 4 * slot;
      if (rst) begin
         m_s[i] = 0; m_act[i] = 16'h0; m_pend[i] = 16'h0;
         m_adp[i] = 4'h0; m_pdp[i] = 4'h0; m_flag[i] = 1'b0;
         e_fs[i] = 1'b0;
      end else begin
         p   = m_s[i] % period;
         dig = p / slot;
         w   = p % slot;
         e_fs[i] = (p == 0);
         if (w >= P_B[i]) begin
            pwm  = (w - P_B[i]) % 16;
            lit  = (bright == 4'hF) || (pwm < int'(bright));
            allz = 1'b1;
            for (int k = 0; k <= dig; k++)
               if (nibble(m_act[i], k) != 4'h0 || m_adp[i][3-k]) allz = 1'b0;
            if (lit && !(lz_en && allz && dig != 3)) begin
               sel[3-dig] = 1'b1;
               seg        = glyph(nibble(m_act[i], dig));
               d          = m_adp[i][3-dig];
            end
         end
         if ((m_s[i] + 1) % period == 0) begin
            if (m_flag[i]) begin
               m_act[i] = m_pend[i];
               m_adp[i] = m_pdp[i];
            end
            m_flag[i] = load;
         end else if (load) begin
            m_flag[i] = 1'b1;
         end
         if (load) begin
            m_pend[i] = bcd;
            m_pdp[i]  = dp;
         end
         m_s[i]++;
      end
      e_sel[i] = (P_SELL[i] != 0) ? ~sel : sel;
      e_seg[i] = (P_SEGL[i] != 0) ? ~seg : seg;
      e_dp[i]  = (P_SEGL[i] != 0) ? ~d : d;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      check("a_sel", 32'(a_sel), 32'(e_sel[0]));
      check("a_seg", 32'(a_seg), 32'(e_seg[0]));
      check("a_dp",  32'(a_dp),  32'(e_dp[0]));
      check("a_fs",  32'(a_fs),  32'(e_fs[0]));
      check("b_sel", 32'(b_sel), 32'(e_sel[1]));
      check("b_seg", 32'(b_seg), 32'(e_seg[1]));
      check("b_dp",  32'(b_dp),  32'(e_dp[1]));
      check("b_fs",  32'(b_fs),  32'(e_fs[1]));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge(0);
      model_edge(1);
      @(negedge clk);
      check_all();
   endtask

   task automatic run(input int n);
      for (int c = 0; c < n; c++) step();
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] d);
      bcd = v; dp = d; load = 1'b1;
      step();
      load = 1'b0;
   endtask

   initial begin
      bit found;
      int p;

      // reset and basic scan
      run(3);
      rst = 1'b0;
      do_load(16'h1234, 4'h0);
      run(140);

      // leading-zero suppression and decimal point
      lz_en = 1'b1;
      do_load(16'h0045, 4'h0);  run(140);
      do_load(16'h0000, 4'h0);  run(140);
      do_load(16'h0000, 4'h4);  run(140);

      // brightness
      lz_en = 1'b0;
      bright = 4'd4;  run(140);
      bright = 4'd0;  run(70);
      bright = 4'hF;  run(70);

      // back-to-back loads mid-frame
      do_load(16'h1111, 4'h0);
      do_load(16'h2222, 4'h0);
      run(140);

      // load coincident with the frame-start transfer edge
      found = 1'b0;
      for (int g = 0; g < 100 && !found; g++) begin
         if (m_s[0] % 48 == 47) found = 1'b1;
         else step();
      end
      n_checks++;
      assert (found) else begin
         n_errors++;
         $error("FAIL align_wait: observed=timeout expected=frame edge");
      end
      do_load(16'h3333, 4'h0);
      run(140);

      // non-decimal codes
      do_load(16'hFABC, 4'h0);  run(140);
      do_load(16'hDE9F, 4'hA);  run(140);

      // asynchronous reset while digit 2 is lit
      found = 1'b0;
      for (int g = 0; g < 100 && !found; g++) begin
         step();
         p = (m_s[0] - 1) % 48;
         if (p / 12 == 2 && p % 12 >= 4) found = 1'b1;
      end
      n_checks++;
      assert (found) else begin
         n_errors++;
         $error("FAIL digit2_wait: observed=timeout expected=digit 2 on");
      end
      check("pre_rst_a_sel", 32'(a_sel), 32'h2);
      #2 rst = 1'b1;
      #1;
      check("rst_a_sel", 32'(a_sel), 32'h0);
      check("rst_a_seg", 32'(a_seg), 32'h7F);
      check("rst_a_dp",  32'(a_dp),  32'h1);
      check("rst_a_fs",  32'(a_fs),  32'h0);
      check("rst_b_sel", 32'(b_sel), 32'hF);
      check("rst_b_seg", 32'(b_seg), 32'h00);
      check("rst_b_dp",  32'(b_dp),  32'h0);
      run(2);
      rst = 1'b0;
      step();
      check("rel_a_fs",  32'(a_fs),  32'h1);
      check("rel_b_fs",  32'(b_fs),  32'h1);
      check("rel_a_sel", 32'(a_sel), 32'h0);

      // randomized traffic
      for (int c = 0; c < 1500; c++) begin
         load = 1'b0;
         if ($urandom_range(0, 19) == 0) begin
            load = 1'b1;
            bcd  = 16'($urandom) >> (4 * $urandom_range(0, 4));
            dp   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
         end
         if ($urandom_range(0, 99) == 0)  bright = 4'($urandom);
         if ($urandom_range(0, 199) == 0) lz_en  = ~lz_en;
         rst = ($urandom_range(0, 699) == 0);
         step();
      end
      load = 1'b0;
      rst  = 1'b0;
      run(2);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
